// File: rtl/insn_fetch_queue.sv
// Instruction fetch queue: issues PC requests to a synchronous ROM and buffers responses for the
// decoder. Define FETCH_BYPASS_EN to forward a response straight to the decoder when the queue is empty.
module insn_fetch_queue #(
  parameter int unsigned   L       = 10,
  parameter int unsigned   W       = 9,
  parameter int unsigned   DEPTH   = 4,
  parameter logic [W-1:0]  HALT_OP = 9'h1FF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [L-1:0] ProgCtr,
  input  logic         PcValid,
  input  logic         Redirect,
  output logic         FetchStall,
  output logic [L-1:0] MemAddr,
  input  logic [W-1:0] MemRdData,
  output logic [W-1:0] InsnOut,
  output logic [L-1:0] InsnPc,
  output logic         InsnValid,
  input  logic         InsnReady,
  output logic         Done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    data_q [DEPTH];
  logic [L-1:0]    pc_q   [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            req_pending_q, req_pending_d;
  logic [L-1:0]    req_pc_q, req_pc_d;
  logic            done_q, done_d;

  logic            running;
  logic            fifo_empty;
  logic [CW:0]     occupancy;
  logic            ext_flush;
  logic            bypass_valid;
  logic            head_valid;
  logic [W-1:0]    head_data;
  logic [L-1:0]    head_pc;
  logic            handshake;
  logic            halt_accept;
  logic            flush;
  logic            req_accept;
  logic            enq;
  logic            deq;

  assign running    = (state_q == StRun);
  assign fifo_empty = (count_q == '0);
  // In-flight reads hold a credit so their responses always find a free slot.
  assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, req_pending_q};
  assign FetchStall = ~running | (occupancy >= (CW + 1)'(DEPTH));
  assign MemAddr    = ProgCtr;
  assign ext_flush  = Redirect | Start;

`ifdef FETCH_BYPASS_EN
  assign bypass_valid = req_pending_q & fifo_empty & ~ext_flush;
`else
  assign bypass_valid = 1'b0;
`endif

  assign head_valid = ~fifo_empty | bypass_valid;
  assign head_data  = fifo_empty ? MemRdData : data_q[head_q];
  assign head_pc    = fifo_empty ? req_pc_q : pc_q[head_q];

  assign InsnValid  = head_valid;
  assign InsnOut    = head_valid ? head_data : '0;
  assign InsnPc     = head_valid ? head_pc : '0;
  assign Done       = done_q;

  assign handshake   = head_valid & InsnReady;
  assign halt_accept = running & handshake & (head_data == HALT_OP);
  assign flush       = ext_flush | halt_accept;
  assign req_accept  = running & PcValid & ~FetchStall & ~flush;

  // A bypassed response consumed in its arrival cycle never touches the storage.
  assign enq = req_pending_q & ~flush & ~(bypass_valid & InsnReady);
  assign deq = ~fifo_empty & InsnReady & ~flush;

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    req_pending_d = req_accept;
    req_pc_d      = req_accept ? ProgCtr : req_pc_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + AW'(1);
      if (deq) head_d = head_q + AW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    case (state_q)
      StIdle, StHalt: begin
        if (Start) state_d = StRun;
      end
      StRun: begin
        if (!Start && halt_accept) state_d = StHalt;
      end
      default: state_d = StIdle;
    endcase
    if (Start) begin
      done_d = 1'b0;
    end else if (halt_accept) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StIdle;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      req_pending_q <= 1'b0;
      req_pc_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      req_pending_q <= req_pending_d;
      req_pc_q      <= req_pc_d;
      done_q        <= done_d;
    end
  end

  // Storage is unreset; outputs are gated by InsnValid so stale contents never leak.
  always_ff @(posedge Clk) begin
    if (!Reset && enq) begin
      data_q[tail_q] <= MemRdData;
      pc_q[tail_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Directed bench for insn_fetch_queue (default build): reset, streaming, back-pressure, redirect,
// halt/restart, pointer wrap and mid-run reset.
module tb_insn_fetch_queue;

  localparam int unsigned L     = 10;
  localparam int unsigned W     = 9;
  localparam int unsigned DEPTH = 4;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [L-1:0] ProgCtr;
  logic         PcValid;
  logic         Redirect;
  logic         FetchStall;
  logic [L-1:0] MemAddr;
  logic [W-1:0] MemRdData;
  logic [W-1:0] InsnOut;
  logic [L-1:0] InsnPc;
  logic         InsnValid;
  logic         InsnReady;
  logic         Done;

  int errors = 0;
  int checks = 0;
  logic [L-1:0] halt_addr = '1;

  insn_fetch_queue #(
    .L      (L),
    .W      (W),
    .DEPTH  (DEPTH),
    .HALT_OP(9'h1FF)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .ProgCtr   (ProgCtr),
    .PcValid   (PcValid),
    .Redirect  (Redirect),
    .FetchStall(FetchStall),
    .MemAddr   (MemAddr),
    .MemRdData (MemRdData),
    .InsnOut   (InsnOut),
    .InsnPc    (InsnPc),
    .InsnValid (InsnValid),
    .InsnReady (InsnReady),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] rom(input logic [L-1:0] a);
    if (a == halt_addr) return 9'h1FF;
    return W'(a) + 9'h10;
  endfunction

  always @(posedge Clk) MemRdData <= rom(MemAddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int accepted;
    int delivered;
    logic take;

    Reset = 1'b1; Start = 1'b0; ProgCtr = '0; PcValid = 1'b0; Redirect = 1'b0; InsnReady = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_stall", 32'(FetchStall), 32'd1);
    chk("rst_valid", 32'(InsnValid), 32'd0);
    chk("rst_done",  32'(Done), 32'd0);
    chk("rst_out",   32'(InsnOut), 32'd0);
    chk("rst_pc",    32'(InsnPc), 32'd0);
    tick();
    chk("idle_stall", 32'(FetchStall), 32'd1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start_stall", 32'(FetchStall), 32'd0);

    // Streaming: entry j appears two cycles after its request.
    InsnReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      PcValid = (i < 4);
      ProgCtr = L'(i);
      tick();
      if (i >= 1 && i <= 4) begin
        chk("stream_valid", 32'(InsnValid), 32'd1);
        chk("stream_out",   32'(InsnOut), 32'h10 + 32'(i - 1));
        chk("stream_pc",    32'(InsnPc), 32'(i - 1));
      end else begin
        chk("stream_idle", 32'(InsnValid), 32'd0);
      end
    end

    // Back-pressure: four requests fit, then the credit rule stalls the PC.
    InsnReady = 1'b0;
    for (int k = 0; k < 8; k++) begin
      PcValid = 1'b1;
      ProgCtr = L'(16 + ((k < 4) ? k : 4));
      chk("bp_stall", 32'(FetchStall), 32'(k >= 4));
      tick();
    end
    PcValid = 1'b0;
    InsnReady = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("drain_valid", 32'(InsnValid), 32'd1);
      chk("drain_out",   32'(InsnOut), 32'h20 + 32'(j));
      chk("drain_pc",    32'(InsnPc), 32'd16 + 32'(j));
      chk("drain_stall", 32'(FetchStall), 32'(j == 0));
      tick();
    end
    chk("drain_empty", 32'(InsnValid), 32'd0);

    // Redirect alongside PC 7: PC 6 in flight is discarded, PC 7 dropped, PC 40 accepted next.
    PcValid = 1'b1; ProgCtr = L'(5);
    tick();
    ProgCtr = L'(6);
    tick();
    chk("redir_pc5", 32'(InsnPc), 32'd5);
    Redirect = 1'b1; ProgCtr = L'(7);
    tick();
    Redirect = 1'b0;
    chk("redir_flushed", 32'(InsnValid), 32'd0);
    chk("redir_stall", 32'(FetchStall), 32'd0);
    ProgCtr = L'(40);
    tick();
    PcValid = 1'b0;
    chk("redir_gap", 32'(InsnValid), 32'd0);
    tick();
    chk("redir_valid", 32'(InsnValid), 32'd1);
    chk("redir_pc40",  32'(InsnPc), 32'd40);
    chk("redir_out40", 32'(InsnOut), 32'h38);
    tick();
    chk("redir_after", 32'(InsnValid), 32'd0);

    // Halt at ROM[3].
    halt_addr = L'(3);
    for (int i = 0; i < 6; i++) begin
      PcValid = 1'b1;
      ProgCtr = L'(i);
      tick();
      if (i >= 1 && i <= 4) begin
        chk("halt_pc",   32'(InsnPc), 32'(i - 1));
        chk("halt_out",  32'(InsnOut), (i == 4) ? 32'h1FF : 32'h10 + 32'(i - 1));
        chk("halt_done", 32'(Done), 32'd0);
      end else if (i == 5) begin
        chk("halted_valid", 32'(InsnValid), 32'd0);
        chk("halted_done",  32'(Done), 32'd1);
        chk("halted_stall", 32'(FetchStall), 32'd1);
      end
    end
    tick();
    tick();
    chk("halt_hold_valid", 32'(InsnValid), 32'd0);
    chk("halt_hold_done",  32'(Done), 32'd1);
    PcValid = 1'b0;
    halt_addr = '1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("restart_done",  32'(Done), 32'd0);
    chk("restart_stall", 32'(FetchStall), 32'd0);
    PcValid = 1'b1; ProgCtr = L'(8);
    tick();
    PcValid = 1'b0;
    tick();
    chk("restart_pc",  32'(InsnPc), 32'd8);
    chk("restart_out", 32'(InsnOut), 32'h18);
    tick();

    // Pointer wrap: ten instructions, decoder ready on alternate cycles.
    accepted = 0;
    delivered = 0;
    for (int c = 0; c < 60; c++) begin
      InsnReady = (c % 2 == 0);
      PcValid = (accepted < 10);
      ProgCtr = L'(100 + accepted);
      take = PcValid & ~FetchStall;
      if (InsnValid && InsnReady) begin
        chk("wrap_pc",  32'(InsnPc), 32'(100 + delivered));
        chk("wrap_out", 32'(InsnOut), 32'(rom(L'(100 + delivered))));
        delivered++;
      end
      chk("wrap_credit", 32'((accepted - delivered) <= int'(DEPTH)), 32'd1);
      if (take) accepted++;
      tick();
    end
    chk("wrap_delivered", 32'(delivered), 32'd10);
    chk("wrap_empty", 32'(InsnValid), 32'd0);

    // Reset overrides a simultaneous Start with requests in flight.
    InsnReady = 1'b0;
    PcValid = 1'b1; ProgCtr = L'(200);
    tick();
    tick();
    Reset = 1'b1; Start = 1'b1;
    tick();
    Reset = 1'b0; Start = 1'b0; PcValid = 1'b0;
    chk("midrst_stall", 32'(FetchStall), 32'd1);
    chk("midrst_valid", 32'(InsnValid), 32'd0);
    chk("midrst_done",  32'(Done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/insn_fetch_queue.md
# insn_fetch_queue

Instruction fetch queue between the program counter and the instruction decoder. It acts as the consumer of the PC address stream: it issues each PC value to the synchronous instruction ROM, captures the returned 9-bit instruction with its PC, and buffers it in a small FIFO. The decoder drains the FIFO through a valid/ready handshake. The block back-pressures the PC when the FIFO is full, flushes on a taken jump, and runs a start/halt state machine that drives `Done`.

## Interface
- `L`, default 10: PC / ROM address width.
- `W`, default 9: instruction width.
- `DEPTH`, default 4: FIFO entries; must be a power of two and ≥ 2.
- `HALT_OP`, default 9'h1FF: encoding that ends a program.

- `Clk`  in  1: single clock; everything updates on the posedge.
- `Reset`  in  1: synchronous, active-high.
- `Start`  in  1: begin or restart program fetch.
- `ProgCtr`  in  L: fetch address from the PC.
- `PcValid`  in  1: `ProgCtr` carries a fetch request this cycle.
- `Redirect`  in  1: taken jump; flush everything.
- `FetchStall`  out  1: PC must hold; a request made while this is high is ignored.
- `MemAddr`  out  L: ROM address (combinational copy of `ProgCtr`).
- `MemRdData`  in  W: ROM data; valid one cycle after `MemAddr`.
- `InsnOut`  out  W: head-of-queue instruction.
- `InsnPc`  out  L: PC of `InsnOut`.
- `InsnValid`  out  1: head entry valid.
- `InsnReady`  in  1: decoder accepts the head entry.
- `Done`  out  1: halt instruction consumed; sticky.

## Operation
- **FSM states:** IDLE, RUN, HALT.
  - Reset → IDLE.
  - IDLE or HALT with `Start` → RUN.
  - RUN → HALT when an entry equal to `HALT_OP` is accepted (`InsnValid && InsnReady`).
  - `Start` in RUN restarts: flush, stay in RUN.
- **Request acceptance:** a request is accepted when state is RUN, `PcValid=1`, `FetchStall=0` and `Redirect=0`. On acceptance the block registers `ReqPending<=1` and `ReqPc<=ProgCtr`.
- **Response capture:** on the cycle after an accepted request, `{MemRdData, ReqPc}` is written to the FIFO tail.
- **Credit rule:** `FetchStall = (state!=RUN) | (count + ReqPending >= DEPTH)`. This reserves a slot for every in-flight read, so the FIFO never overflows and a response is never dropped for lack of space.
- **Dequeue:** when `InsnValid && InsnReady`, the head pointer advances.
- **Simultaneous enqueue and dequeue:** count is unchanged; this is legal even at count = DEPTH.
- **Flush:** triggered by `Redirect`, by `Start`, or by entry into HALT. A flush clears count and both pointers and discards any in-flight response (`ReqPending<=0`). A request presented in the flush cycle is dropped. Flush has priority over enqueue and dequeue in the same cycle.
- **Pointers:** log2(DEPTH) bits, wrapping modulo DEPTH. Count is log2(DEPTH)+1 bits.
- **HALT:** the halt instruction itself is delivered to the decoder. After it is accepted, `InsnValid=0` and `FetchStall=1` until `Start`.
- **`Done`:** set on entry to HALT; cleared by `Reset` or `Start`.

## Timing
- **Reset values:** state IDLE, `InsnValid=0`, `InsnOut=0`, `InsnPc=0`, `FetchStall=1`, `Done=0`, count 0, `ReqPending=0`.
- **Latency:** a request accepted in cycle t is written at the t+1 edge, so `InsnValid` rises in cycle t+2 when the FIFO is empty. The bypass option reduces this; see Configuration.
- **Throughput:** one request per cycle while `FetchStall=0`. With `InsnReady` held high, the queue sustains one instruction per cycle.
- **`FetchStall`:** combinational from registered state. It deasserts in the cycle after the dequeue that frees a slot.
- **`Redirect`:** takes effect at the next edge. The PC's first new-target request is accepted in the following cycle.
- **Mid-operation `Reset`:** overrides all other activity, including `Start`.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When the FIFO is empty and a response arrives, `InsnOut`/`InsnPc`/`InsnValid` are driven combinationally from `MemRdData`/`ReqPc`.
  - If `InsnReady=1` that cycle, the entry is not written. Otherwise it is written normally.
  - Latency becomes t+1.
  - Flush in the response cycle suppresses the bypass (`InsnValid=0`).
- `FETCH_BYPASS_EN` undefined: every response passes through the FIFO; latency is t+2.

## Test plan
- **Reset and start:** `Reset` for 2 cycles, then idle → `FetchStall=1`, `InsnValid=0`, `Done=0`. Pulse `Start` → `FetchStall=0` next cycle.
- **Streaming:** PC 0,1,2,3 on consecutive cycles, ROM = addr+9'h10, `InsnReady=1` → `InsnOut` 0x10, 0x11, 0x12, 0x13 with `InsnPc` 0..3 on consecutive cycles, first at t+2 (t+1 with bypass).
- **Back-pressure:** DEPTH=4, `InsnReady=0`, PC streams → exactly 4 requests accepted, `FetchStall=1` thereafter, no data loss. Raise `InsnReady` → entries drain in order, then `FetchStall` drops.
- **Redirect:** PC 5,6,7 with `Redirect` asserted alongside PC 7, then PC 40 → decoder sees only entries accepted before the flush that were already dequeued. Next valid `InsnPc=40`; in-flight PC 6 response discarded.
- **Halt:** ROM[3]=9'h1FF, stream from PC 0 → entries 0–3 delivered, `Done=1` after PC 3 accepted, `FetchStall=1`, no further `InsnValid`. `Start` → `Done=0`, fetch resumes.
- **Pointer wrap:** 10 instructions through DEPTH=4 with `InsnReady` toggling 1,0,1,0 → in-order delivery, count never exceeds 4.
